// File: rtl/aes_ks_seq_pkg.sv
// Shared types and constants for the AES-128 key schedule sequencer.
//   NUM_ROUNDS      : last round index (AES-128 only)
//   BYTES_PER_ROUND : bytes per round key, sets the counter width
//   KEY_MEM_DEPTH   : number of round-key memory bytes
//   addr_of()       : round-key memory address for a (round, byte) pair
package aes_ks_seq_pkg;

    localparam int unsigned NUM_ROUNDS      = 10;
    localparam int unsigned BYTES_PER_ROUND = 16;
    localparam int unsigned KEY_MEM_DEPTH   = (NUM_ROUNDS + 1) * BYTES_PER_ROUND;
    localparam int unsigned CNT_W           = $clog2(BYTES_PER_ROUND);
    localparam int unsigned ADDR_W          = 8;

    localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(NUM_ROUNDS);
    localparam logic [CNT_W-1:0] LAST_BYTE  = CNT_W'(BYTES_PER_ROUND - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoadKey,
        StExpand,
        StReady,
        StStream
    } ks_state_e;

    function automatic logic [ADDR_W-1:0] addr_of(input logic [CNT_W-1:0] rnd,
                                                  input logic [CNT_W-1:0] byt);
        return ADDR_W'(rnd) * ADDR_W'(BYTES_PER_ROUND) + ADDR_W'(byt);
    endfunction

endpackage

// File: rtl/aes_key_schedule_sequencer_if.sv
// Signal bundle between the core controller / key schedule datapath and the sequencer.
//   slave  : sequencer side (takes key/block commands, drives datapath controls)
//   master : core controller and datapath side
interface aes_key_schedule_sequencer_if;
    import aes_ks_seq_pkg::*;

    logic              key_start;
    logic              key_valid;
    logic              key_ready;
    logic              blk_start;
    logic              blk_encrypt;
    logic              keys_ready;
    logic              blk_busy;
    logic              stream_valid;
    logic [CNT_W-1:0]  stream_round;
    logic [CNT_W-1:0]  stream_byte;
    logic              blk_done;
    logic              en_generator;
    logic [CNT_W-1:0]  round_counter;
    logic [CNT_W-1:0]  inner_state_counter;
    logic              encrypt;
    logic              read_key_in;
    logic              load_round_key;
    logic              save_round_key;
    logic [ADDR_W-1:0] addr_round_key_mem;

    modport slave (
        input  key_start, key_valid, blk_start, blk_encrypt,
        output key_ready, keys_ready, blk_busy, stream_valid, stream_round, stream_byte,
               blk_done, en_generator, round_counter, inner_state_counter, encrypt,
               read_key_in, load_round_key, save_round_key, addr_round_key_mem
    );

    modport master (
        output key_start, key_valid, blk_start, blk_encrypt,
        input  key_ready, keys_ready, blk_busy, stream_valid, stream_round, stream_byte,
               blk_done, en_generator, round_counter, inner_state_counter, encrypt,
               read_key_in, load_round_key, save_round_key, addr_round_key_mem
    );

endinterface

// File: rtl/aes_ks_round_byte_counter.sv
// Byte counter (0..15) chained to a round counter, shared by load, expand and stream.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load         : byte <= 0, round <= i_load_round (wins over i_en)
//   i_en           : advance byte; on byte wrap step the round
//   i_down         : round steps down instead of up on byte wrap
//   o_round/o_byte : current counts; o_byte_last flags byte 15
module aes_ks_round_byte_counter
    import aes_ks_seq_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_round,
    input  logic             i_en,
    input  logic             i_down,
    output logic [CNT_W-1:0] o_round,
    output logic [CNT_W-1:0] o_byte,
    output logic             o_byte_last
);

    logic [CNT_W-1:0] r_round;
    logic [CNT_W-1:0] r_byte;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_round <= '0;
            r_byte  <= '0;
        end else if (i_load) begin
            r_round <= i_load_round;
            r_byte  <= '0;
        end else if (i_en) begin
            if (r_byte == LAST_BYTE) begin
                r_byte  <= '0;
                r_round <= i_down ? r_round - CNT_W'(1) : r_round + CNT_W'(1);
            end else begin
                r_byte <= r_byte + CNT_W'(1);
            end
        end
    end

    assign o_round     = r_round;
    assign o_byte      = r_byte;
    assign o_byte_last = (r_byte == LAST_BYTE);

endmodule

// File: rtl/aes_key_schedule_sequencer.sv
// Sequencer for the byte-serial AES-128 key schedule: loads a 16-byte key, runs the
// generator through rounds 1..10 writing every round-key byte, then replays the cached
// round keys forward (encrypt) or reverse (decrypt).
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   io_ks          : command handshake, stream status and datapath controls
module aes_key_schedule_sequencer
    import aes_ks_seq_pkg::*;
(
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    aes_key_schedule_sequencer_if.slave   io_ks
);

    ks_state_e         r_state, w_state_next;
    logic              r_encrypt;
    logic              r_stream_valid, r_blk_done;
    logic [CNT_W-1:0]  r_stream_round, r_stream_byte;

    logic [CNT_W-1:0]  w_round, w_byte, w_cnt_load_round;
    logic              w_byte_last, w_cnt_load, w_cnt_en, w_cnt_down;
    logic              w_blk_accept, w_stream_last, w_in_stream;
    logic              w_key_ready, w_keys_ready, w_blk_busy, w_en_generator, w_encrypt;
    logic              w_read_key_in, w_load_round_key, w_save_round_key;
    logic [CNT_W-1:0]  w_round_counter, w_inner_state_counter;
    logic [ADDR_W-1:0] w_addr;

    aes_ks_round_byte_counter u_counter (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_load       (w_cnt_load),
        .i_load_round (w_cnt_load_round),
        .i_en         (w_cnt_en),
        .i_down       (w_cnt_down),
        .o_round      (w_round),
        .o_byte       (w_byte),
        .o_byte_last  (w_byte_last)
    );

    assign w_in_stream = (r_state == StStream);

    always_comb begin
        w_state_next          = r_state;
        w_key_ready           = 1'b0;
        w_keys_ready          = 1'b0;
        w_blk_busy            = 1'b0;
        w_en_generator        = 1'b0;
        w_encrypt             = 1'b0;
        w_read_key_in         = 1'b0;
        w_load_round_key      = 1'b0;
        w_save_round_key      = 1'b0;
        w_round_counter       = '0;
        w_inner_state_counter = '0;
        w_addr                = '0;
        w_cnt_load            = 1'b0;
        w_cnt_load_round      = '0;
        w_cnt_en              = 1'b0;
        w_cnt_down            = 1'b0;
        w_blk_accept          = 1'b0;
        w_stream_last         = 1'b0;

        case (r_state)
            StIdle: ;
            StLoadKey: begin
                w_key_ready           = 1'b1;
                w_read_key_in         = 1'b1;
                w_encrypt             = 1'b1;
                w_round_counter       = w_round;
                w_inner_state_counter = w_byte;
                if (io_ks.key_valid) begin
                    w_en_generator   = 1'b1;
                    w_save_round_key = 1'b1;
                    w_addr           = addr_of(w_round, w_byte);
                    // Byte 15 wraps the counter to round 1, byte 0: the first expand step.
                    w_cnt_en         = 1'b1;
                    if (w_byte_last) w_state_next = StExpand;
                end
            end
            StExpand: begin
                w_en_generator        = 1'b1;
                w_save_round_key      = 1'b1;
                w_encrypt             = 1'b1;
                w_round_counter       = w_round;
                w_inner_state_counter = w_byte;
                w_addr                = addr_of(w_round, w_byte);
                if (w_byte_last && w_round == LAST_ROUND) begin
                    w_cnt_load   = 1'b1;
                    w_state_next = StReady;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            StReady: begin
                // While the last streamed byte is still draining, stay unavailable.
                w_keys_ready = !r_stream_valid;
                if (io_ks.blk_start && !r_stream_valid) begin
                    w_blk_accept     = 1'b1;
                    w_cnt_load       = 1'b1;
                    w_cnt_load_round = io_ks.blk_encrypt ? '0 : LAST_ROUND;
                    w_state_next     = StStream;
                end
            end
            StStream: begin
                w_load_round_key = 1'b1;
                w_blk_busy       = 1'b1;
                w_addr           = addr_of(w_round, w_byte);
                w_stream_last    = w_byte_last && (w_round == (r_encrypt ? LAST_ROUND : '0));
                if (w_stream_last) begin
                    w_cnt_load   = 1'b1;
                    w_state_next = StReady;
                end else begin
                    w_cnt_en   = 1'b1;
                    w_cnt_down = !r_encrypt;
                end
            end
            default: w_state_next = StIdle;
        endcase

        // Drain cycle: memory read data for the final address is still on its way out.
        if (r_stream_valid) begin
            w_load_round_key = 1'b1;
            w_blk_busy       = 1'b1;
        end

        if (io_ks.key_start) begin
            w_state_next     = StLoadKey;
            w_cnt_load       = 1'b1;
            w_cnt_load_round = '0;
            w_cnt_en         = 1'b0;
            w_blk_accept     = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= StIdle;
            r_encrypt      <= 1'b0;
            r_stream_valid <= 1'b0;
            r_stream_round <= '0;
            r_stream_byte  <= '0;
            r_blk_done     <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            if (w_blk_accept) r_encrypt <= io_ks.blk_encrypt;
            r_stream_valid <= w_in_stream;
            r_stream_round <= w_in_stream ? w_round : '0;
            r_stream_byte  <= w_in_stream ? w_byte : '0;
            r_blk_done     <= w_stream_last;
        end
    end

    assign io_ks.key_ready           = w_key_ready;
    assign io_ks.keys_ready          = w_keys_ready;
    assign io_ks.blk_busy            = w_blk_busy;
    assign io_ks.stream_valid        = r_stream_valid;
    assign io_ks.stream_round        = r_stream_round;
    assign io_ks.stream_byte         = r_stream_byte;
    assign io_ks.blk_done            = r_blk_done;
    assign io_ks.en_generator        = w_en_generator;
    assign io_ks.round_counter       = w_round_counter;
    assign io_ks.inner_state_counter = w_inner_state_counter;
    assign io_ks.encrypt             = w_encrypt;
    assign io_ks.read_key_in         = w_read_key_in;
    assign io_ks.load_round_key      = w_load_round_key;
    assign io_ks.save_round_key      = w_save_round_key;
    assign io_ks.addr_round_key_mem  = w_addr;

endmodule
